// File: rtl/dff_async_rst.sv
// Purpose: WIDTH-bit D register with clock enable, synchronous clear and complementary outputs q/qb.
// Latency: one clk from d to q on the rising edge; qb follows q combinationally.
// Backpressure: none; en=0 holds the stored value, and clr overrides en.
module dff_async_rst #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Storage: the async reset dominates, then clear, then enabled capture; otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (clr) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

    // qb is derived from q, not stored separately, so every bit of qb is always the inverse of q.
    assign qb = ~q;

endmodule

// File: tb/tb_dff_async_rst.sv
module tb_dff_async_rst;

    localparam int OP_NONE = 0;
    localparam int OP_RISE = 1;
    localparam int OP_FALL = 2;

    logic       clk;
    logic       reset1, en1, clr1;
    logic [0:0] d1, q1, qb1;
    logic       reset8, en8, clr8;
    logic [7:0] d8, q8, qb8;

    int total;
    int bad;

    dff_async_rst #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk   (clk),
        .reset (reset1),
        .en    (en1),
        .clr   (clr1),
        .d     (d1),
        .q     (q1),
        .qb    (qb1)
    );

    dff_async_rst #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
        .clk   (clk),
        .reset (reset8),
        .en    (en8),
        .clr   (clr8),
        .d     (d8),
        .q     (q8),
        .qb    (qb8)
    );

    typedef struct {
        logic  rst;
        logic  en;
        logic  clr;
        logic  d;
        int    op;
        logic  exp_q;
        string name;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic rst, input logic en, input logic clr,
                           input logic d, input int op, input logic exp_q, input string name);
        vecs[i].rst   = rst;
        vecs[i].en    = en;
        vecs[i].clr   = clr;
        vecs[i].d     = d;
        vecs[i].op    = op;
        vecs[i].exp_q = exp_q;
        vecs[i].name  = name;
    endtask

    // Rising edge on the shared clock; drops the clock first if it is already high.
    task automatic rise();
        if (clk == 1'b1) begin
            clk = 1'b0;
            #2;
        end
        clk = 1'b1;
        #2;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clk    = 1'b0;
        reset1 = 1'b0;
        en1    = 1'b0;
        clr1   = 1'b0;
        d1     = 1'bx;
        reset8 = 1'b0;
        en8    = 1'b0;
        clr8   = 1'b0;
        d8     = 8'hxx;

        //        idx rst en clr d     op       exp   name
        set_vec( 0, 0, 0, 0, 1'bx, OP_NONE, 1'b0, "async_rst_x");
        set_vec( 1, 0, 1, 0, 1'b1, OP_RISE, 1'b0, "rst_hold_edge");
        set_vec( 2, 0, 1, 0, 1'bx, OP_FALL, 1'b0, "rst_hold_fall");
        set_vec( 3, 1, 1, 0, 1'b1, OP_NONE, 1'b0, "release_no_clk");
        set_vec( 4, 1, 1, 0, 1'b1, OP_RISE, 1'b1, "capture");
        set_vec( 5, 1, 1, 0, 1'b0, OP_FALL, 1'b1, "fall_no_effect");
        set_vec( 6, 1, 0, 0, 1'b0, OP_RISE, 1'b1, "en_hold");
        set_vec( 7, 1, 1, 1, 1'b1, OP_RISE, 1'b0, "clr_beats_en");
        set_vec( 8, 1, 1, 0, 1'b1, OP_RISE, 1'b1, "recapture");
        set_vec( 9, 1, 0, 1, 1'b1, OP_RISE, 1'b0, "clr_without_en");
        set_vec(10, 1, 1, 0, 1'b1, OP_RISE, 1'b1, "recapture2");
        set_vec(11, 0, 1, 0, 1'b1, OP_NONE, 1'b0, "mid_rst");
        set_vec(12, 0, 1, 0, 1'b1, OP_RISE, 1'b0, "mid_rst_edge");
        set_vec(13, 0, 1, 0, 1'b1, OP_RISE, 1'b0, "mid_rst_edge2");
        set_vec(14, 1, 1, 0, 1'b1, OP_NONE, 1'b0, "release_again");
        set_vec(15, 1, 1, 0, 1'b1, OP_RISE, 1'b1, "first_edge_after_release");
        set_vec(16, 1, 1, 0, 1'b0, OP_RISE, 1'b0, "capture_zero");

        for (int i = 0; i < 17; i++) begin
            reset1 = vecs[i].rst;
            en1    = vecs[i].en;
            clr1   = vecs[i].clr;
            d1     = vecs[i].d;
            case (vecs[i].op)
                OP_RISE: rise();
                OP_FALL: begin clk = 1'b0; #2; end
                default: #1;
            endcase
            check({vecs[i].name, "_q"},  {7'd0, q1},  {7'd0, vecs[i].exp_q});
            check({vecs[i].name, "_qb"}, {7'd0, qb1}, {7'd0, ~vecs[i].exp_q});
        end

        // Capture a 1, then assert reset in the same step as a rising edge: reset must win.
        en1 = 1'b1; clr1 = 1'b0; d1 = 1'b1;
        rise();
        check("pre_simul_q", {7'd0, q1}, 8'h01);
        clk = 1'b0;
        #2;
        clk    = 1'b1;
        reset1 = 1'b0;
        #1;
        check("simul_rst_edge_q",  {7'd0, q1},  8'h00);
        check("simul_rst_edge_qb", {7'd0, qb1}, 8'h01);

        // 8-bit instance with a non-zero reset value.
        #1;
        check("w8_rst_q",  q8,  8'hA5);
        check("w8_rst_qb", qb8, 8'h5A);
        reset8 = 1'b1; en8 = 1'b1; clr8 = 1'b0; d8 = 8'h3C;
        #1;
        check("w8_release_q", q8, 8'hA5);
        rise();
        check("w8_cap_q",  q8,  8'h3C);
        check("w8_cap_qb", qb8, 8'hC3);
        en8 = 1'b0; d8 = 8'hFF;
        rise();
        check("w8_hold_q", q8, 8'h3C);
        clr8 = 1'b1;
        rise();
        check("w8_clr_q",  q8,  8'hA5);
        check("w8_clr_qb", qb8, 8'h5A);
        clr8 = 1'b0; en8 = 1'b1; d8 = 8'h96;
        rise();
        check("w8_cap2_q", q8, 8'h96);
        reset8 = 1'b0;
        #1;
        check("w8_mid_rst_q",  q8,  8'hA5);
        check("w8_mid_rst_qb", qb8, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
